// File: rtl/dec_vp_pkg.sv
// Shared types, default sizes and PC field helpers for the decode stride value-prediction table.
package dec_vp_pkg;

   localparam int VP_ENTRIES     = 64;
   localparam int VP_TAG_W       = 10;
   localparam int VP_CONF_W      = 2;
   localparam int VP_CONF_THRESH = 3;

   typedef struct packed {
      logic                 valid;
      logic [VP_TAG_W-1:0]  tag;
      logic [63:0]          last_value;
      logic [63:0]          stride;
      logic [VP_CONF_W-1:0] conf;
   } vp_entry_t;

   // pc arrives as [63:1], so bit 0 of the vector is already pc[1]
   function automatic logic [63:0] vp_idx(input logic [63:1] pc, input int idx_w);
      return {1'b0, pc} & ((64'd1 << idx_w) - 64'd1);
   endfunction

   function automatic logic [63:0] vp_tag(input logic [63:1] pc, input int idx_w, input int tag_w);
      return ({1'b0, pc} >> idx_w) & ((64'd1 << tag_w) - 64'd1);
   endfunction

endpackage

// File: rtl/dec_vp_train.sv
// Combinational training rule: old entry + committed outcome -> new entry.
// Used by both the table write port and the same-cycle lookup bypass.
module dec_vp_train
   import dec_vp_pkg::*;
#(
   parameter int CONF_W = VP_CONF_W
) (
   input  vp_entry_t           old_entry,
   input  logic [VP_TAG_W-1:0] upd_tag,
   input  logic [63:0]         upd_actual,
   input  logic                upd_mispredict,
   input  logic                hit,
   output vp_entry_t           new_entry
);

   localparam logic [VP_CONF_W-1:0] CONF_MAX = VP_CONF_W'((1 << CONF_W) - 1);

   logic [63:0] new_stride;

   always_comb begin
      new_stride = upd_actual - old_entry.last_value;
      new_entry  = old_entry;
      if (hit) begin
         new_entry.last_value = upd_actual;
         if (new_stride == old_entry.stride) begin
            if (old_entry.conf != CONF_MAX) begin
               new_entry.conf = old_entry.conf + VP_CONF_W'(1);
            end
         end else begin
            new_entry.stride = new_stride;
            new_entry.conf   = '0;
         end
         if (upd_mispredict) begin
            new_entry.conf = '0;
         end
      end else begin
         new_entry.valid      = 1'b1;
         new_entry.tag        = upd_tag;
         new_entry.last_value = upd_actual;
         new_entry.stride     = '0;
         new_entry.conf       = '0;
      end
   end

endmodule

// File: rtl/dec_vp_table.sv
// Direct-mapped stride value predictor: PC lookup in decode, trained from commit.
// One-cycle registered lookup, write-first on same-index update; no back-pressure.
module dec_vp_table
   import dec_vp_pkg::*;
#(
   parameter int ENTRIES     = VP_ENTRIES,
   parameter int TAG_W       = VP_TAG_W,
   parameter int CONF_W      = VP_CONF_W,
   parameter int CONF_THRESH = VP_CONF_THRESH
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              freeze,
   input  logic              flush,
   input  logic              lookup_valid,
   input  logic [63:1]       lookup_pc,
   output logic              pred_valid,
   output logic              pred_hit,
   output logic [63:0]       predicted_result,
   output logic [CONF_W-1:0] pred_conf,
   input  logic              upd_valid,
   input  logic [63:1]       upd_pc,
   input  logic [63:0]       upd_actual,
   input  logic              upd_mispredict
);

   localparam int IDX_W = $clog2(ENTRIES);

   vp_entry_t           table_q [ENTRIES];
   vp_entry_t           table_d [ENTRIES];

   logic [IDX_W-1:0]    lk_idx;
   logic [IDX_W-1:0]    upd_idx;
   logic [VP_TAG_W-1:0] lk_tag;
   logic [VP_TAG_W-1:0] upd_tag;
   vp_entry_t           upd_old;
   vp_entry_t           upd_new;
   vp_entry_t           lk_entry;
   logic                upd_hit;
   logic                lk_hit;

   logic                pred_valid_q, pred_valid_d;
   logic                pred_hit_q, pred_hit_d;
   logic [63:0]         pred_result_q, pred_result_d;
   logic [CONF_W-1:0]   pred_conf_q, pred_conf_d;

   always_comb begin
      lk_idx  = IDX_W'(vp_idx(lookup_pc, IDX_W));
      lk_tag  = VP_TAG_W'(vp_tag(lookup_pc, IDX_W, TAG_W));
      upd_idx = IDX_W'(vp_idx(upd_pc, IDX_W));
      upd_tag = VP_TAG_W'(vp_tag(upd_pc, IDX_W, TAG_W));
      upd_old = table_q[upd_idx];
      upd_hit = upd_old.valid && (upd_old.tag == upd_tag);
   end

   dec_vp_train #(
      .CONF_W         (CONF_W)
   ) u_train (
      .old_entry      (upd_old),
      .upd_tag        (upd_tag),
      .upd_actual     (upd_actual),
      .upd_mispredict (upd_mispredict),
      .hit            (upd_hit),
      .new_entry      (upd_new)
   );

   always_comb begin
      table_d = table_q;
      if (upd_valid) begin
         table_d[upd_idx] = upd_new;
      end
   end

   // Write-first: a same-index update is visible to this cycle's lookup, tag included
   always_comb begin
      lk_entry = (upd_valid && (upd_idx == lk_idx)) ? upd_new : table_q[lk_idx];
      lk_hit   = lk_entry.valid && (lk_entry.tag == lk_tag);
   end

   always_comb begin
      pred_valid_d  = pred_valid_q;
      pred_hit_d    = pred_hit_q;
      pred_result_d = pred_result_q;
      pred_conf_d   = pred_conf_q;
      if (!freeze) begin
         if (flush || !lookup_valid) begin
            pred_valid_d  = 1'b0;
            pred_hit_d    = 1'b0;
            pred_result_d = '0;
            pred_conf_d   = '0;
         end else begin
            pred_hit_d    = lk_hit;
            pred_valid_d  = lk_hit && (int'(lk_entry.conf) >= CONF_THRESH);
            pred_result_d = lk_entry.last_value + lk_entry.stride;
            pred_conf_d   = lk_hit ? CONF_W'(lk_entry.conf) : '0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < ENTRIES; i++) begin
            table_q[i] <= '0;
         end
         pred_valid_q  <= 1'b0;
         pred_hit_q    <= 1'b0;
         pred_result_q <= '0;
         pred_conf_q   <= '0;
      end else begin
         table_q       <= table_d;
         pred_valid_q  <= pred_valid_d;
         pred_hit_q    <= pred_hit_d;
         pred_result_q <= pred_result_d;
         pred_conf_q   <= pred_conf_d;
      end
   end

   assign pred_valid       = pred_valid_q;
   assign pred_hit         = pred_hit_q;
   assign predicted_result = pred_result_q;
   assign pred_conf        = pred_conf_q;

endmodule

// File: tb/tb_dec_vp_table.sv
// Bench for dec_vp_table: reference model feeds an expected-output queue, drained one cycle later.
module tb_dec_vp_table;

   localparam int ENTRIES = 64;

   logic        clk = 1'b0;
   logic        rst;
   logic        freeze;
   logic        flush;
   logic        lookup_valid;
   logic [63:1] lookup_pc;
   logic        pred_valid;
   logic        pred_hit;
   logic [63:0] predicted_result;
   logic [1:0]  pred_conf;
   logic        upd_valid;
   logic [63:1] upd_pc;
   logic [63:0] upd_actual;
   logic        upd_mispredict;

   always #5 clk = ~clk;

   dec_vp_table dut (
      .clk              (clk),
      .rst              (rst),
      .freeze           (freeze),
      .flush            (flush),
      .lookup_valid     (lookup_valid),
      .lookup_pc        (lookup_pc),
      .pred_valid       (pred_valid),
      .pred_hit         (pred_hit),
      .predicted_result (predicted_result),
      .pred_conf        (pred_conf),
      .upd_valid        (upd_valid),
      .upd_pc           (upd_pc),
      .upd_actual       (upd_actual),
      .upd_mispredict   (upd_mispredict)
   );

   typedef struct packed {
      logic        v;
      logic        h;
      logic [63:0] res;
      logic [1:0]  conf;
   } out_t;

   out_t        exp_q[$];
   out_t        exp_prev;

   logic        m_v      [ENTRIES];
   logic [9:0]  m_tag    [ENTRIES];
   logic [63:0] m_last   [ENTRIES];
   logic [63:0] m_stride [ENTRIES];
   logic [1:0]  m_conf   [ENTRIES];

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < ENTRIES; i++) begin
         m_v[i] = 1'b0; m_tag[i] = '0; m_last[i] = '0; m_stride[i] = '0; m_conf[i] = '0;
      end
      exp_prev = '0;
   endtask

   // One clock: drive inputs, predict the registered output, then compare after the edge
   task automatic cyc(input logic frz, input logic fl, input logic lv, input logic [63:0] lpc,
                      input logic uv, input logic [63:0] upc, input logic [63:0] uact, input logic umis);
      int          li, ui;
      logic [9:0]  lt, ut;
      logic [63:0] ds, nlast, nstr, elast, estr;
      logic [1:0]  nconf, econf;
      logic        ev, hit;
      logic [9:0]  etag;
      out_t        e, got;
      freeze = frz; flush = fl; lookup_valid = lv; lookup_pc = lpc[63:1];
      upd_valid = uv; upd_pc = upc[63:1]; upd_actual = uact; upd_mispredict = umis;
      li = int'(lpc[6:1]); lt = lpc[16:7];
      ui = int'(upc[6:1]); ut = upc[16:7];
      nlast = uact; nstr = '0; nconf = '0;
      if (m_v[ui] && m_tag[ui] == ut) begin
         ds = uact - m_last[ui];
         nstr = ds;
         nconf = (ds != m_stride[ui]) ? 2'd0 : (m_conf[ui] == 2'd3) ? 2'd3 : m_conf[ui] + 2'd1;
         if (umis) nconf = 2'd0;
      end
      if (frz) begin
         e = exp_prev;
      end else if (fl || !lv) begin
         e = '0;
      end else begin
         if (uv && ui == li) begin
            ev = 1'b1; etag = ut; elast = nlast; estr = nstr; econf = nconf;
         end else begin
            ev = m_v[li]; etag = m_tag[li]; elast = m_last[li]; estr = m_stride[li]; econf = m_conf[li];
         end
         hit    = ev && (etag == lt);
         e.h    = hit;
         e.v    = hit && (econf >= 2'd3);
         e.res  = elast + estr;
         e.conf = hit ? econf : 2'd0;
      end
      exp_q.push_back(e);
      @(posedge clk);
      if (uv) begin
         m_v[ui] = 1'b1; m_tag[ui] = ut; m_last[ui] = nlast; m_stride[ui] = nstr; m_conf[ui] = nconf;
      end
      #1;
      got = exp_q.pop_front();
      check_eq("pred_valid", 64'(pred_valid), 64'(got.v));
      check_eq("pred_hit", 64'(pred_hit), 64'(got.h));
      check_eq("predicted_result", predicted_result, got.res);
      check_eq("pred_conf", 64'(pred_conf), 64'(got.conf));
      exp_prev = got;
   endtask

   task automatic lk(input logic [63:0] pc);
      cyc(1'b0, 1'b0, 1'b1, pc, 1'b0, 64'd0, 64'd0, 1'b0);
   endtask

   task automatic train(input logic [63:0] pc, input logic [63:0] val, input logic mis);
      cyc(1'b0, 1'b0, 1'b0, 64'd0, 1'b1, pc, val, mis);
   endtask

   logic [63:0] pcs [4];
   logic [63:0] seqv[4];

   initial begin
      rst = 1'b1; freeze = 1'b0; flush = 1'b0; lookup_valid = 1'b0; lookup_pc = '0;
      upd_valid = 1'b0; upd_pc = '0; upd_actual = '0; upd_mispredict = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_eq("rst_pred_valid", 64'(pred_valid), 64'd0);
      check_eq("rst_pred_hit", 64'(pred_hit), 64'd0);
      check_eq("rst_result", predicted_result, 64'd0);
      check_eq("rst_conf", 64'(pred_conf), 64'd0);
      rst = 1'b0;

      lk(64'h1000);
      check_eq("cold_hit", 64'(pred_hit), 64'd0);
      check_eq("cold_result", predicted_result, 64'd0);

      for (int i = 0; i < 5; i++) train(64'h1000, 64'(100 + 8 * i), 1'b0);
      lk(64'h1000);
      check_eq("trained_hit", 64'(pred_hit), 64'd1);
      check_eq("trained_conf", 64'(pred_conf), 64'd3);
      check_eq("trained_valid", 64'(pred_valid), 64'd1);
      check_eq("trained_result", predicted_result, 64'd140);

      train(64'h1000, 64'd200, 1'b1);
      lk(64'h1000);
      check_eq("mispred_valid", 64'(pred_valid), 64'd0);
      check_eq("mispred_result", predicted_result, 64'd268);
      check_eq("mispred_conf", 64'(pred_conf), 64'd0);

      train(64'h1000 + 64'(ENTRIES << 1), 64'd55, 1'b0);
      lk(64'h1000);
      check_eq("alias_hit", 64'(pred_hit), 64'd0);

      for (int i = 0; i < 4; i++) train(64'h1000, 64'(100 + 8 * i), 1'b0);
      cyc(1'b0, 1'b0, 1'b1, 64'h1000, 1'b1, 64'h1000, 64'd132, 1'b0);
      check_eq("bypass_conf", 64'(pred_conf), 64'd3);
      check_eq("bypass_result", predicted_result, 64'd140);
      check_eq("bypass_valid", 64'(pred_valid), 64'd1);

      for (int i = 0; i < 3; i++) begin
         cyc(1'b1, 1'b0, 1'b1, 64'h1002, 1'b0, 64'd0, 64'd0, 1'b0);
         check_eq("freeze_result", predicted_result, 64'd140);
         check_eq("freeze_valid", 64'(pred_valid), 64'd1);
      end

      cyc(1'b0, 1'b1, 1'b1, 64'h1000, 1'b0, 64'd0, 64'd0, 1'b0);
      check_eq("flush_valid", 64'(pred_valid), 64'd0);

      train(64'h2002, 64'hFFFF_FFFF_FFFF_FFF0, 1'b0);
      train(64'h2002, 64'h8, 1'b0);
      lk(64'h2002);
      check_eq("wrap_result", predicted_result, 64'h20);

      pcs[0] = 64'h1000; pcs[1] = 64'h1080; pcs[2] = 64'h1002; pcs[3] = 64'h3000;
      for (int k = 0; k < 4; k++) seqv[k] = 64'(k * 1000);
      for (int n = 0; n < 300; n++) begin
         int a, b;
         logic [63:0] v;
         a = $urandom_range(0, 3);
         b = $urandom_range(0, 3);
         seqv[b] = seqv[b] + 64'd24;
         v = ($urandom_range(0, 5) == 0) ? {$urandom, $urandom} : seqv[b];
         cyc($urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0, pcs[a],
             $urandom_range(0, 2) != 0, pcs[b], v, $urandom_range(0, 9) == 0);
      end

      freeze = 1'b0; flush = 1'b0; lookup_valid = 1'b0;
      upd_valid = 1'b1; upd_pc = 63'(64'h1000 >> 1); upd_actual = 64'd999; upd_mispredict = 1'b0;
      #1 rst = 1'b1;
      #1;
      check_eq("midrst_valid", 64'(pred_valid), 64'd0);
      check_eq("midrst_result", predicted_result, 64'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      upd_valid = 1'b0;
      model_reset();
      for (int k = 0; k < 4; k++) begin
         lk(pcs[k]);
         check_eq("post_rst_hit", 64'(pred_hit), 64'd0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/dec_vp_table.md
Name: dec_vp_table

Overview:
Stride value-prediction table in the decode stage, directly upstream of the value-prediction flush control. Decode looks it up by instruction PC and gets a registered 64-bit predicted result plus a confidence-qualified valid. That prediction travels down the pipe and is compared against the actual result at e4. The commit-side outcome (actual result, mispredict flush) is written back here to train last value, stride and confidence.

Parameters:
ENTRIES, 64, number of direct-mapped entries (power of 2)
IDX_W, $clog2(ENTRIES), index width (derived, not overridden)
TAG_W, 10, partial PC tag width
CONF_W, 2, saturating confidence counter width
CONF_THRESH, 3, minimum confidence for pred_valid=1 (≤ 2^CONF_W-1)

Ports:
clk  in  1  top-level clock
rst  in  1  asynchronous, active-high reset
freeze  in  1  decode stall; holds the lookup output register
flush  in  1  pipeline flush; kills the in-flight lookup result
lookup_valid  in  1  decode lookup request
lookup_pc  in  63  [63:1] PC of the decoding instruction
pred_valid  out  1  hit and conf ≥ CONF_THRESH; consumer uses predicted_result
pred_hit  out  1  tag hit regardless of confidence
predicted_result  out  64  last_value + stride
pred_conf  out  CONF_W  confidence of the hit entry (0 on miss)
upd_valid  in  1  commit-side training request
upd_pc  in  63  [63:1] PC of the trained instruction
upd_actual  in  64  actual result
upd_mispredict  in  1  flush_upper_vp of the trained instruction

Behaviour:
- Index = pc[IDX_W:1]. Tag = pc[IDX_W+TAG_W:IDX_W+1].
- Entry fields: valid, tag[TAG_W], last_value[64], stride[64] (two's complement), conf[CONF_W].
- Reset (async, rst=1): all entry valid=0, conf=0, last_value=0, stride=0. Outputs pred_valid=0, pred_hit=0, predicted_result=0, pred_conf=0. Reset mid-operation discards any pending lookup or update.
- Lookup latency is 1 cycle. A lookup at cycle N is visible on the outputs at N+1.
- Output register update per cycle:
  - freeze=1: outputs hold.
  - else flush=1 or lookup_valid=0: pred_valid=0, pred_hit=0, pred_conf=0, predicted_result=0.
  - else: outputs load from the indexed entry.
- flush takes priority over lookup_valid. freeze takes priority over flush for the output register.
- Hit = entry.valid & entry.tag == lookup tag.
- predicted_result = last_value + stride, modulo 2^64 (wrap, no saturation).
- Training on upd_valid takes effect at the next clock edge. Training is not gated by freeze or flush.
- Training, hit case: new_stride = upd_actual − last_value (mod 2^64).
  - If new_stride == stride: conf = conf+1, saturating at 2^CONF_W−1.
  - Else: stride = new_stride, conf = 0.
  - In both cases: last_value = upd_actual.
  - upd_mispredict=1 forces conf=0 after the above.
- Training, miss or invalid entry: allocate (replace) with valid=1, tag=upd tag, last_value=upd_actual, stride=0, conf=0.
- Same-cycle lookup and update to the same index: write-first forwarding. The lookup output reflects the post-update entry, including tag replacement. Different indices are independent.
- At most one lookup and one update per cycle. There is no back-pressure.

Decomposition:
- Package dec_vp_pkg holds:
  - vp_entry_t struct (valid, tag, last_value, stride, conf)
  - VP_ENTRIES, VP_TAG_W, VP_CONF_W, VP_CONF_THRESH defaults
  - functions vp_idx() and vp_tag()
- Sub-module dec_vp_train (combinational): takes the old entry plus upd_actual, upd_mispredict and hit, and returns the new entry. It is shared by the array write path and the write-first bypass.

Test Plan:
- Reset, then lookup PC 0x1000 → next cycle pred_hit=0, pred_valid=0, predicted_result=0.
- Train PC 0x1000 with 100,108,116,124,132 in consecutive cycles, then lookup → pred_hit=1, pred_conf=3, pred_valid=1, predicted_result=140.
- From the trained state, update with 200 and upd_mispredict=1 → stride=68, conf=0. Lookup → pred_valid=0, predicted_result=268.
- Aliasing: trained PC 0x1000, then train PC 0x1000+(ENTRIES<<1)·… with an index collision but a different tag → replaced. Lookup of PC 0x1000 → pred_hit=0.
- Same cycle: lookup and update to the same PC (state conf=2, last=124, stride=8; update 132) → output shows conf=3, predicted_result=140, pred_valid=1.
- Freeze/flush/rst:
  - freeze=1 for 3 cycles after a valid prediction → outputs stable.
  - flush with lookup_valid=1 → pred_valid=0 next cycle.
  - rst asserted mid-training → all lookups miss afterwards.
